// File: rtl/vai_audit_tx_if.sv
// vai_audit_tx_if
// Shared CCI-P Tx request types plus the bus interface that carries the
// sub-AFU, manager and upstream Tx ports, the per-VM address windows and
// the violation statistics of vai_audit_tx.
// The req_cnt statistics bundle exists only when VAI_AUDIT_TX_STATS_EN is defined.

package vai_audit_tx_pkg;

    localparam int CCIP_CLADDR_WIDTH = 42;

    typedef struct packed {
        logic [3:0]                   req_type;
        logic [CCIP_CLADDR_WIDTH-1:0] address;
        logic [15:0]                  mdata;
    } t_ccip_ReqHdr;

    typedef struct packed {
        t_ccip_ReqHdr hdr;
        logic         valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_ReqHdr hdr;
        logic [511:0] data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [8:0]  tid;
        logic        mmioRdValid;
        logic [63:0] data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

endpackage

interface vai_audit_tx_if #(
    parameter int NUM_SUB_AFUS = 8
);
    import vai_audit_tx_pkg::*;

    t_if_ccip_Tx [NUM_SUB_AFUS-1:0]                         afu_TxPort;
    t_if_ccip_Tx                                            mgr_TxPort;
    logic        [NUM_SUB_AFUS-1:0][CCIP_CLADDR_WIDTH-1:0]  vm_offset;
    logic        [NUM_SUB_AFUS-1:0][CCIP_CLADDR_WIDTH-1:0]  vm_limit;
    t_if_ccip_Tx [NUM_SUB_AFUS:0]                           up_TxPort;
    logic        [NUM_SUB_AFUS-1:0][15:0]                   viol_cnt;
    logic        [NUM_SUB_AFUS-1:0]                         viol_err;
`ifdef VAI_AUDIT_TX_STATS_EN
    logic        [NUM_SUB_AFUS-1:0][31:0]                   req_cnt;
`endif

    // Request side: drives traffic and windows, observes upstream and stats
    modport master (
        output afu_TxPort, mgr_TxPort, vm_offset, vm_limit,
`ifdef VAI_AUDIT_TX_STATS_EN
        input  req_cnt,
`endif
        input  up_TxPort, viol_cnt, viol_err
    );

    // Audit block side
    modport slave (
        input  afu_TxPort, mgr_TxPort, vm_offset, vm_limit,
`ifdef VAI_AUDIT_TX_STATS_EN
        output req_cnt,
`endif
        output up_TxPort, viol_cnt, viol_err
    );

endinterface

// File: rtl/vai_audit_tx.sv
// vai_audit_tx
// Tx-side audit stage. Each sub-AFU lane is registered (T1), bounds-checked,
// translated and VMID-stamped (T2), then forwarded or dropped (T3). Dropped
// requests are counted per lane with saturation and latch a sticky flag.
// The manager lane (index NUM_SUB_AFUS) rides the same 3-stage pipe untouched.
// Optional: define VAI_AUDIT_TX_STATS_EN to add per-lane forwarded-request counters.

module vai_audit_tx
    import vai_audit_tx_pkg::*;
#(
    parameter int NUM_SUB_AFUS = 8,
    parameter int VMID_WIDTH   = $clog2(NUM_SUB_AFUS)
) (
    input  logic          clk,
    input  logic          reset,
    vai_audit_tx_if.slave bus
);

    localparam int NUM_LANES = NUM_SUB_AFUS + 1;
    localparam int CLW       = CCIP_CLADDR_WIDTH;

    logic        [NUM_LANES-1:0]          rstLane_q;
    logic        [NUM_LANES-1:0]          laneClr;
    t_if_ccip_Tx [NUM_LANES-1:0]          lanesIn;
    t_if_ccip_Tx [NUM_LANES-1:0]          t1_q;
    t_if_ccip_Tx [NUM_LANES-1:0]          t2_d;
    t_if_ccip_Tx [NUM_LANES-1:0]          t2_q;
    t_if_ccip_Tx [NUM_LANES-1:0]          up_d;
    t_if_ccip_Tx [NUM_LANES-1:0]          up_q;
    logic        [NUM_SUB_AFUS-1:0]       c0Bad_d;
    logic        [NUM_SUB_AFUS-1:0]       c0Bad_q;
    logic        [NUM_SUB_AFUS-1:0]       c1Bad_d;
    logic        [NUM_SUB_AFUS-1:0]       c1Bad_q;
    logic        [NUM_SUB_AFUS-1:0][1:0]  dropCnt;
    logic        [NUM_SUB_AFUS-1:0][16:0] violSum;
    logic        [NUM_SUB_AFUS-1:0][15:0] violCnt_d;
    logic        [NUM_SUB_AFUS-1:0][15:0] violCnt_q;
    logic        [NUM_SUB_AFUS-1:0]       violErr_d;
    logic        [NUM_SUB_AFUS-1:0]       violErr_q;
`ifdef VAI_AUDIT_TX_STATS_EN
    logic        [NUM_SUB_AFUS-1:0][1:0]  fwdCnt;
    logic        [NUM_SUB_AFUS-1:0][31:0] reqCnt_d;
    logic        [NUM_SUB_AFUS-1:0][31:0] reqCnt_q;
`endif

    // Manager lane sits on the top index so lane numbering matches up_TxPort
    assign lanesIn = {bus.mgr_TxPort, bus.afu_TxPort};

    // A request is illegal if it already carries VMID bits, falls outside the
    // VM window, or would wrap the address space once translated
    function automatic logic reqIllegal(input t_ccip_ReqHdr hdr,
                                        input logic [CLW-1:0] off,
                                        input logic [CLW-1:0] lim);
        logic [CLW:0] sum;
        sum = {1'b0, hdr.address} + {1'b0, off};
        return (hdr.mdata[15 -: VMID_WIDTH] != '0) || (hdr.address >= lim) || sum[CLW];
    endfunction

    // Translate into the VM's host window and claim the mdata top bits for routing
    function automatic t_ccip_ReqHdr stampHdr(input t_ccip_ReqHdr hdr,
                                              input logic [CLW-1:0] off,
                                              input logic [VMID_WIDTH-1:0] vmid);
        t_ccip_ReqHdr res;
        res                          = hdr;
        res.address                  = hdr.address + off;
        res.mdata[15 -: VMID_WIDTH]  = vmid;
        return res;
    endfunction

    // Per-lane reset fan-out register
    always_ff @(posedge clk) begin
        rstLane_q <= {NUM_LANES{reset}};
    end

    // The raw reset also clears directly so nothing escapes during the fan-out cycle
    assign laneClr = ~rstLane_q | {NUM_LANES{~reset}};

    // T1: register every lane's c0/c1/c2 inputs
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (laneClr[l]) begin
                t1_q[l] <= '0;
            end else begin
                t1_q[l] <= lanesIn[l];
            end
        end
    end

    // T2: check and stamp valid c0/c1 requests on sub-AFU lanes using current windows
    always_comb begin
        t2_d    = t1_q;
        c0Bad_d = '0;
        c1Bad_d = '0;
        for (int n = 0; n < NUM_SUB_AFUS; n++) begin
            if (t1_q[n].c0.valid) begin
                c0Bad_d[n]     = reqIllegal(t1_q[n].c0.hdr, bus.vm_offset[n], bus.vm_limit[n]);
                t2_d[n].c0.hdr = stampHdr(t1_q[n].c0.hdr, bus.vm_offset[n], VMID_WIDTH'(n));
            end
            if (t1_q[n].c1.valid) begin
                c1Bad_d[n]     = reqIllegal(t1_q[n].c1.hdr, bus.vm_offset[n], bus.vm_limit[n]);
                t2_d[n].c1.hdr = stampHdr(t1_q[n].c1.hdr, bus.vm_offset[n], VMID_WIDTH'(n));
            end
        end
    end

    // T2 register: stamped request plus its verdict
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (laneClr[l]) begin
                t2_q[l] <= '0;
            end else begin
                t2_q[l] <= t2_d[l];
            end
        end
        for (int n = 0; n < NUM_SUB_AFUS; n++) begin
            if (laneClr[n]) begin
                c0Bad_q[n] <= 1'b0;
                c1Bad_q[n] <= 1'b0;
            end else begin
                c0Bad_q[n] <= c0Bad_d[n];
                c1Bad_q[n] <= c1Bad_d[n];
            end
        end
    end

    // T3: squash illegal requests and fold the drops into the saturating counters
    always_comb begin
        up_d      = t2_q;
        dropCnt   = '0;
        violSum   = '0;
        violCnt_d = violCnt_q;
        violErr_d = violErr_q;
        for (int n = 0; n < NUM_SUB_AFUS; n++) begin
            if (c0Bad_q[n]) begin
                up_d[n].c0 = '0;
            end
            if (c1Bad_q[n]) begin
                up_d[n].c1.valid = 1'b0;
                up_d[n].c1.hdr   = '0;
            end
            dropCnt[n]   = {1'b0, c0Bad_q[n]} + {1'b0, c1Bad_q[n]};
            violSum[n]   = {1'b0, violCnt_q[n]} + 17'(dropCnt[n]);
            violCnt_d[n] = violSum[n][16] ? 16'hFFFF : violSum[n][15:0];
            if (dropCnt[n] != 2'd0) begin
                violErr_d[n] = 1'b1;
            end
        end
    end

`ifdef VAI_AUDIT_TX_STATS_EN
    // Forwarded-request count advances as the legal requests reach the output
    always_comb begin
        fwdCnt   = '0;
        reqCnt_d = reqCnt_q;
        for (int n = 0; n < NUM_SUB_AFUS; n++) begin
            fwdCnt[n]   = {1'b0, t2_q[n].c0.valid & ~c0Bad_q[n]} +
                          {1'b0, t2_q[n].c1.valid & ~c1Bad_q[n]};
            reqCnt_d[n] = reqCnt_q[n] + 32'(fwdCnt[n]);
        end
    end

    // Forwarded-request counter registers
    always_ff @(posedge clk) begin
        for (int n = 0; n < NUM_SUB_AFUS; n++) begin
            if (laneClr[n]) begin
                reqCnt_q[n] <= '0;
            end else begin
                reqCnt_q[n] <= reqCnt_d[n];
            end
        end
    end

    assign bus.req_cnt = reqCnt_q;
`endif

    // T3 register: upstream outputs and violation statistics
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (laneClr[l]) begin
                up_q[l] <= '0;
            end else begin
                up_q[l] <= up_d[l];
            end
        end
        for (int n = 0; n < NUM_SUB_AFUS; n++) begin
            if (laneClr[n]) begin
                violCnt_q[n] <= '0;
                violErr_q[n] <= 1'b0;
            end else begin
                violCnt_q[n] <= violCnt_d[n];
                violErr_q[n] <= violErr_d[n];
            end
        end
    end

    assign bus.up_TxPort = up_q;
    assign bus.viol_cnt  = violCnt_q;
    assign bus.viol_err  = violErr_q;

endmodule

// File: tb/tb_vai_audit_tx.sv
// tb_vai_audit_tx
// Directed and randomized traffic for vai_audit_tx, compared every cycle
// against a reference built from the audit rules: an output in cycle m comes
// from the request driven in cycle m-3 judged against the windows of cycle m-2.
// Build with VAI_AUDIT_TX_STATS_EN defined to also cover req_cnt.

module tb_vai_audit_tx;
    import vai_audit_tx_pkg::*;

    localparam int NS = 8;
    localparam int VW = 3;
    localparam int CLW = CCIP_CLADDR_WIDTH;
    localparam longint unsigned AMASK = (64'd1 << CLW) - 64'd1;
    localparam logic [15:0] LOWMASK = 16'((32'd1 << (16 - VW)) - 32'd1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vai_audit_tx_if #(.NUM_SUB_AFUS(NS)) bus ();

    vai_audit_tx #(.NUM_SUB_AFUS(NS), .VMID_WIDTH(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = 8;

    t_if_ccip_Tx     inH  [8][NS];
    t_if_ccip_Tx     mgrH [8];
    longint unsigned offH [8][NS];
    longint unsigned limH [8][NS];
    bit              rstLowH [8];

    logic [15:0] expViol [NS];
    bit          expErr  [NS];
    logic [31:0] expReq  [NS];

    task automatic checkField(input int lane, input string field,
                              input logic [575:0] obs, input logic [575:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL lane%0d.%s observed=%0h expected=%0h", lane, field, obs, exp);
        end
    endtask

    function automatic bit modelBad(input t_ccip_ReqHdr h, input longint unsigned off,
                                    input longint unsigned lim);
        longint unsigned a;
        a = longint'(h.address);
        return ((h.mdata & ~LOWMASK) != 16'd0) || (a >= lim) || ((a + off) > AMASK);
    endfunction

    function automatic t_ccip_ReqHdr modelStamp(input t_ccip_ReqHdr h, input longint unsigned off,
                                                input int n);
        t_ccip_ReqHdr r;
        r         = h;
        r.address = CLW'((longint'(h.address) + off) & AMASK);
        r.mdata   = (h.mdata & LOWMASK) | 16'(n << (16 - VW));
        return r;
    endfunction

    task automatic modelLane(input t_if_ccip_Tx req, input longint unsigned off,
                             input longint unsigned lim, input int n,
                             output t_if_ccip_Tx o, output int drops, output int fwd);
        o = req;
        drops = 0;
        fwd = 0;
        if (req.c0.valid) begin
            if (modelBad(req.c0.hdr, off, lim)) begin
                o.c0 = '0;
                drops++;
            end else begin
                o.c0.hdr = modelStamp(req.c0.hdr, off, n);
                fwd++;
            end
        end
        if (req.c1.valid) begin
            if (modelBad(req.c1.hdr, off, lim)) begin
                o.c1.valid = 1'b0;
                o.c1.hdr   = '0;
                drops++;
            end else begin
                o.c1.hdr = modelStamp(req.c1.hdr, off, n);
                fwd++;
            end
        end
    endtask

    // An edge clears the block if reset was low in its own or the preceding cycle
    function automatic bit clr(input int k);
        return rstLowH[k & 7] || rstLowH[(k - 1) & 7];
    endfunction

    task automatic checkOutput();
        int          m;
        bit          alive;
        t_if_ccip_Tx e;
        int          drops;
        int          fwd;
        int          s;
        m = cyc;
        alive = !clr(m - 1) && !clr(m - 2) && !clr(m - 3);
        for (int n = 0; n < NS; n++) begin
            if (clr(m - 1)) begin
                expViol[n] = '0;
                expErr[n]  = 1'b0;
                expReq[n]  = '0;
            end
            if (alive) begin
                modelLane(inH[(m - 3) & 7][n], offH[(m - 2) & 7][n], limH[(m - 2) & 7][n],
                          n, e, drops, fwd);
            end else begin
                e = '0;
                drops = 0;
                fwd = 0;
            end
            s = int'(expViol[n]) + drops;
            expViol[n] = (s > 65535) ? 16'hFFFF : 16'(s);
            if (drops != 0) expErr[n] = 1'b1;
            expReq[n] = expReq[n] + 32'(fwd);
            checkField(n, "c0", 576'(bus.up_TxPort[n].c0), 576'(e.c0));
            checkField(n, "c1hdr", 576'({bus.up_TxPort[n].c1.valid, bus.up_TxPort[n].c1.hdr}),
                       576'({e.c1.valid, e.c1.hdr}));
            checkField(n, "c1data", 576'(bus.up_TxPort[n].c1.data), 576'(e.c1.data));
            checkField(n, "c2", 576'(bus.up_TxPort[n].c2), 576'(e.c2));
            checkField(n, "viol_cnt", 576'(bus.viol_cnt[n]), 576'(expViol[n]));
            checkField(n, "viol_err", 576'(bus.viol_err[n]), 576'(expErr[n]));
`ifdef VAI_AUDIT_TX_STATS_EN
            checkField(n, "req_cnt", 576'(bus.req_cnt[n]), 576'(expReq[n]));
`endif
        end
        e = alive ? mgrH[(m - 3) & 7] : '0;
        checkField(NS, "c0", 576'(bus.up_TxPort[NS].c0), 576'(e.c0));
        checkField(NS, "c1", 576'(bus.up_TxPort[NS].c1), 576'(e.c1));
        checkField(NS, "c2", 576'(bus.up_TxPort[NS].c2), 576'(e.c2));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int n = 0; n < NS; n++) begin
            inH[cyc & 7][n]  = bus.afu_TxPort[n];
            offH[cyc & 7][n] = longint'(bus.vm_offset[n]);
            limH[cyc & 7][n] = longint'(bus.vm_limit[n]);
        end
        mgrH[cyc & 7]    = bus.mgr_TxPort;
        rstLowH[cyc & 7] = !reset;
        @(negedge clk);
        cyc++;
        checkOutput();
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic setIdle();
        bus.afu_TxPort = '0;
        bus.mgr_TxPort = '0;
    endtask

    function automatic longint unsigned rnd42();
        return longint'({$urandom(), $urandom()}) & AMASK;
    endfunction

    function automatic longint unsigned pickAddr(input longint unsigned lim);
        case ($urandom_range(3))
            0:       return (lim == 0) ? 64'd0 : lim - 64'd1;
            1:       return lim;
            2:       return (lim == 0) ? rnd42() : rnd42() % lim;
            default: return rnd42();
        endcase
    endfunction

    function automatic t_ccip_ReqHdr randHdr(input longint unsigned lim);
        t_ccip_ReqHdr h;
        h.req_type = 4'($urandom());
        h.address  = CLW'(pickAddr(lim));
        h.mdata    = 16'($urandom());
        if ($urandom_range(3) != 0) h.mdata = h.mdata & LOWMASK;
        return h;
    endfunction

    function automatic t_if_ccip_Tx randReq(input longint unsigned lim);
        t_if_ccip_Tx r;
        r = '0;
        r.c0.valid = 1'($urandom_range(1));
        r.c0.hdr   = randHdr(lim);
        r.c1.valid = 1'($urandom_range(1));
        r.c1.hdr   = randHdr(lim);
        for (int w = 0; w < 16; w++) r.c1.data[w*32 +: 32] = $urandom();
        r.c2.mmioRdValid = 1'($urandom_range(1));
        r.c2.tid         = 9'($urandom());
        r.c2.data        = {$urandom(), $urandom()};
        return r;
    endfunction

    task automatic applyStimulus();
        longint unsigned v;
        for (int n = 0; n < NS; n++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0:       v = 64'd0;
                    1:       v = 64'($urandom_range(1, 4096));
                    2:       v = AMASK;
                    default: v = rnd42();
                endcase
                bus.vm_limit[n] = CLW'(v);
                case ($urandom_range(3))
                    0:       v = 64'd0;
                    1:       v = 64'($urandom_range(0, 65535));
                    2:       v = AMASK - 64'($urandom_range(0, 8));
                    default: v = rnd42();
                endcase
                bus.vm_offset[n] = CLW'(v);
            end
            bus.afu_TxPort[n] = randReq(longint'(bus.vm_limit[n]));
        end
        bus.mgr_TxPort = randReq(AMASK);
    endtask

    initial begin
        logic [NS:0] anyValid;
        for (int i = 0; i < 8; i++) rstLowH[i] = 1'b1;
        for (int n = 0; n < NS; n++) begin
            expViol[n] = '0;
            expErr[n]  = 1'b0;
            expReq[n]  = '0;
        end
        reset = 1'b0;
        setIdle();
        bus.vm_offset = '0;
        for (int n = 0; n < NS; n++) bus.vm_limit[n] = CLW'(64'h1000);

        // Reset state
        ticks(4);
        reset = 1'b1;
        ticks(2);
        checkField(-1, "rst_viol_cnt", 576'(bus.viol_cnt), 576'(0));
        checkField(-1, "rst_viol_err", 576'(bus.viol_err), 576'(0));
        $display("[TB] reset checks done");

        // Lane 3 legal read: translated and stamped
        bus.vm_offset[3] = CLW'(64'h1000);
        bus.vm_limit[3]  = CLW'(64'h100);
        bus.afu_TxPort[3].c0.valid       = 1'b1;
        bus.afu_TxPort[3].c0.hdr.address = CLW'(64'h10);
        bus.afu_TxPort[3].c0.hdr.mdata   = 16'h0055;
        tick();
        setIdle();
        ticks(2);
        checkField(3, "dir_c0_valid", 576'(bus.up_TxPort[3].c0.valid), 576'(1));
        checkField(3, "dir_c0_addr", 576'(bus.up_TxPort[3].c0.hdr.address), 576'(64'h1010));
        checkField(3, "dir_c0_mdata", 576'(bus.up_TxPort[3].c0.hdr.mdata), 576'(16'h6055));

        // Lane 2 write at the limit: dropped and counted
        bus.vm_limit[2] = CLW'(64'h100);
        bus.afu_TxPort[2].c1.valid       = 1'b1;
        bus.afu_TxPort[2].c1.hdr.address = CLW'(64'h100);
        bus.afu_TxPort[2].c1.data        = {16{$urandom()}};
        tick();
        setIdle();
        ticks(2);
        checkField(2, "dir_c1_valid", 576'(bus.up_TxPort[2].c1.valid), 576'(0));
        checkField(2, "dir_viol_cnt", 576'(bus.viol_cnt[2]), 576'(1));
        checkField(2, "dir_viol_err", 576'(bus.viol_err[2]), 576'(1));

        // Lane 4 wrap violation, then an offset change under a legal request
        bus.vm_offset[4] = CLW'(AMASK);
        bus.vm_limit[4]  = CLW'(64'h100);
        bus.afu_TxPort[4].c0.valid       = 1'b1;
        bus.afu_TxPort[4].c0.hdr.address = CLW'(64'h1);
        tick();
        setIdle();
        ticks(2);
        checkField(4, "wrap_c0_valid", 576'(bus.up_TxPort[4].c0.valid), 576'(0));
        checkField(4, "wrap_viol_cnt", 576'(bus.viol_cnt[4]), 576'(1));
        bus.afu_TxPort[4].c0.valid       = 1'b1;
        bus.afu_TxPort[4].c0.hdr.address = CLW'(64'h0);
        tick();
        setIdle();
        tick();
        bus.vm_offset[4] = '0;
        tick();
        checkField(4, "oldoff_c0_valid", 576'(bus.up_TxPort[4].c0.valid), 576'(1));
        checkField(4, "oldoff_c0_addr", 576'(bus.up_TxPort[4].c0.hdr.address), 576'(AMASK));

        // Manager lane pass-through
        bus.mgr_TxPort.c0.valid       = 1'b1;
        bus.mgr_TxPort.c0.hdr.mdata   = 16'hF000;
        bus.mgr_TxPort.c0.hdr.address = CLW'(rnd42());
        bus.mgr_TxPort.c2.mmioRdValid = 1'b1;
        bus.mgr_TxPort.c2.tid         = 9'h1A;
        bus.mgr_TxPort.c2.data        = {$urandom(), $urandom()};
        tick();
        setIdle();
        ticks(2);
        checkField(NS, "mgr_mdata", 576'(bus.up_TxPort[NS].c0.hdr.mdata), 576'(16'hF000));
        checkField(NS, "mgr_tid", 576'(bus.up_TxPort[NS].c2.tid), 576'(9'h1A));
        checkField(NS, "mgr_mmio_valid", 576'(bus.up_TxPort[NS].c2.mmioRdValid), 576'(1));

        // Random traffic with changing windows
        for (int i = 0; i < 400; i++) begin
            applyStimulus();
            tick();
        end
        setIdle();
        ticks(3);
        $display("[TB] random phase done");

        // Saturation on lane 0 from a clean reset
        reset = 1'b0;
        ticks(3);
        reset = 1'b1;
        ticks(2);
        bus.vm_limit[0] = '0;
        bus.afu_TxPort[0].c0.valid       = 1'b1;
        bus.afu_TxPort[0].c0.hdr.address = CLW'(64'h5);
        bus.afu_TxPort[0].c1.valid       = 1'b1;
        bus.afu_TxPort[0].c1.hdr.address = CLW'(64'h6);
        ticks(32767);
        setIdle();
        ticks(3);
        checkField(0, "sat_fffe", 576'(bus.viol_cnt[0]), 576'(16'hFFFE));
        bus.vm_limit[0] = CLW'(64'h100);
        bus.afu_TxPort[0].c0.valid       = 1'b1;
        bus.afu_TxPort[0].c0.hdr.address = CLW'(64'h10);
        bus.afu_TxPort[0].c0.hdr.mdata   = 16'h8000;
        bus.afu_TxPort[0].c1.valid       = 1'b1;
        bus.afu_TxPort[0].c1.hdr.address = CLW'(64'h200);
        tick();
        setIdle();
        ticks(2);
        checkField(0, "sat_ffff", 576'(bus.viol_cnt[0]), 576'(16'hFFFF));
        checkField(0, "sat_c0_valid", 576'(bus.up_TxPort[0].c0.valid), 576'(0));
        bus.afu_TxPort[0].c1.valid       = 1'b1;
        bus.afu_TxPort[0].c1.hdr.address = CLW'(64'h300);
        tick();
        setIdle();
        ticks(2);
        checkField(0, "sat_hold", 576'(bus.viol_cnt[0]), 576'(16'hFFFF));
        $display("[TB] saturation phase done");

        // Reset with traffic in flight on every lane
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            tick();
            for (int l = 0; l <= NS; l++) begin
                anyValid[l] = bus.up_TxPort[l].c0.valid | bus.up_TxPort[l].c1.valid |
                              bus.up_TxPort[l].c2.mmioRdValid;
            end
            checkField(-1, "inrst_valid", 576'(anyValid), 576'(0));
        end
        reset = 1'b1;
        setIdle();
        ticks(2);
        checkField(-1, "post_viol_cnt", 576'(bus.viol_cnt), 576'(0));
        checkField(-1, "post_viol_err", 576'(bus.viol_err), 576'(0));
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vai_audit_tx.md
Name: vai_audit_tx

Overview:
- Tx-side partner of the Rx audit stage; sits between the sub-AFU / manager Tx ports and the upstream CCI-P mux.
- Stamps each sub-AFU request with its VMID in mdata[15-:VMID_WIDTH]; the Rx stage uses those bits to route responses back.
- Translates and bounds-checks each request's cache-line address against per-VM windows; drops and counts illegal requests.
- Passes the manager lane through unmodified.

Parameters:
- NUM_SUB_AFUS, 8, number of sub-AFU lanes; the manager is lane NUM_SUB_AFUS.
- VMID_WIDTH, $clog2(NUM_SUB_AFUS), width of the VMID stamped into mdata top bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- afu_TxPort  in  t_if_ccip_Tx [NUM_SUB_AFUS-1:0]  sub-AFU Tx requests
- mgr_TxPort  in  t_if_ccip_Tx  manager Tx requests
- vm_offset  in  [CCIP_CLADDR_WIDTH-1:0] [NUM_SUB_AFUS-1:0]  per-VM cache-line base added to each request address
- vm_limit  in  [CCIP_CLADDR_WIDTH-1:0] [NUM_SUB_AFUS-1:0]  per-VM window size in cache lines
- up_TxPort  out  t_if_ccip_Tx [NUM_SUB_AFUS:0]  upstream Tx; index NUM_SUB_AFUS carries the manager lane
- viol_cnt  out  [15:0] [NUM_SUB_AFUS-1:0]  per-lane count of dropped requests
- viol_err  out  [NUM_SUB_AFUS-1:0]  per-lane sticky violation flag

Behaviour:
- Reset (reset==0 at a clk edge): every pipeline register, up_TxPort, viol_cnt and viol_err go to 0. Reset is fanned out through one register stage per lane, so the block is quiescent from the 2nd edge after reset asserts. Asserting reset mid-request discards all in-flight requests; none reach upstream.
- Latency: fixed 3 cycles input to up_TxPort on every lane and channel (T1 register, T2 check/stamp, T3 output register). Rate is one request per channel per cycle per lane. No backpressure inside the block; c0TxAlmFull/c1TxAlmFull are honoured by the AFUs outside it.
- T1: register the c0, c1 and c2 inputs of each lane.
- T2, sub-AFU lane n, per c0/c1 request (valid asserted):
  - tag_bad = original mdata[15-:VMID_WIDTH] != 0.
  - range_bad = address >= vm_limit[n].
  - wrap_bad = address + vm_offset[n] carries out of CCIP_CLADDR_WIDTH bits.
  - Request is legal when none of the three is set.
- T2 sampling: vm_offset and vm_limit are read in T2. A change applies to the next request to enter T2, never to one already in T3.
- T3, legal request: forwarded with address = address + vm_offset[n] (truncated) and mdata[15-:VMID_WIDTH] = n. All other header fields and the data are unchanged.
- T3, illegal request: valid is cleared and the header is zeroed. viol_err[n] is set, and cleared only by reset. viol_cnt[n] increases by the number of channels dropped that cycle (0, 1 or 2) and saturates at 16'hFFFF.
- c2 (MMIO read response): passed through on every lane with tid and data unchanged. No stamping, checking or counting.
- Manager lane: c0, c1 and c2 are passed through unmodified with the same 3-cycle latency. It has no counter and no flag.
- Edge cases:
  - vm_limit[n] == 0: every c0/c1 request on lane n is dropped.
  - address == vm_limit[n]-1 with no wrap: forwarded.
  - Simultaneous c0 and c1 violations at count 16'hFFFE: count becomes 16'hFFFF.

Optional Feature:
- VAI_AUDIT_TX_STATS_EN defined: adds output req_cnt [31:0] [NUM_SUB_AFUS-1:0], the per-lane count of forwarded c0+c1 requests. It increments by 0, 1 or 2 in the cycle the request appears on up_TxPort, wraps modulo 2^32, and resets to 0.
- Macro undefined: the port and its counters do not exist. All other behaviour is identical.

Test Plan:
- Lane 3, vm_offset=0x1000, vm_limit=0x100; c0 read with addr=0x10, mdata=0x0055 -> 3 cycles later up_TxPort[3].c0 valid, addr=0x1010, mdata top bits=3, low bits=0x0055.
- Lane 2, vm_limit=0x100; c1 write with addr=0x100 -> nothing upstream; viol_cnt[2]=1 and viol_err[2]=1 three cycles later.
- Lane 0; same-cycle c0 with mdata=0x8000 and c1 out of range, starting from count 0xFFFE -> both dropped; viol_cnt[0]=0xFFFF, and it stays there on further violations.
- vm_offset = all-ones, addr=1 -> wrap violation, request dropped. Then vm_offset=0 written while a legal request is in T3 -> that request keeps the old offset.
- Manager lane c0 with mdata=0xF000 and c2 MMIO response tid=0x1A -> both appear unmodified on up_TxPort[NUM_SUB_AFUS] after 3 cycles.
- reset=0 while requests are in flight on all lanes -> no upstream valid in the following cycles; counters and flags are 0 after release.
